dn_mem_arbiter: RTL and testbench

- Shares one single-port system RAM between the CPU bus and the ioctl download stream.
- Sequences downloads: holds the system in reset while a download runs and for a fixed tail afterwards.
- Buffers download bytes in a small FIFO and backpressures the HPS with ioctl_wait.
- Sits between the top-level emu ioctl pins and the system memory map; runs in the clk_24 domain.

---
 rtl/dn_mem_arbiter_if.sv | 52 +++++
 rtl/dn_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dn_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dn_mem_arbiter_if.sv
// dn_mem_arbiter_if
//   Bundles the ioctl download pins, the CPU request/ack bus, the single-port
//   RAM port and the system status outputs of dn_mem_arbiter.
//   modport slave  : the arbiter's view (ioctl/cpu/mem_dout in, rest out).
//   modport master : the surrounding system's view (directions mirrored).
// Parameters: AW - RAM address width.
interface dn_mem_arbiter_if #(
    parameter int AW = 17
);
    // ioctl download stream from the HPS
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [7:0]    ioctl_index;
    logic          ioctl_wait;
    // CPU bus
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_ack;
    logic [7:0]    cpu_dout;
    // single-port system RAM
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic [7:0]    mem_dout;
    // system status
    logic          sys_reset;
    logic          dn_overflow;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output ioctl_wait,
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_ack, cpu_dout,
        output mem_addr, mem_din, mem_we,
        input  mem_dout,
        output sys_reset, dn_overflow
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  ioctl_wait,
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_ack, cpu_dout,
        input  mem_addr, mem_din, mem_we,
        output mem_dout,
        input  sys_reset, dn_overflow
    );
endinterface

// File: rtl/dn_mem_arbiter.sv
// dn_mem_arbiter
//   Shares one single-port RAM between the CPU bus and the ioctl download
//   stream (clk_24 domain). Download bytes go through a small FIFO with
//   registered ioctl_wait backpressure; the FIFO always wins the RAM over the
//   CPU. sys_reset holds the core in reset during a download and for RST_TAIL
//   cycles after it ends.
// Ports:
//   clk_24      - system clock
//   reset_n     - asynchronous active-low reset
//   bus         - dn_mem_arbiter_if.slave (ioctl, cpu, mem, status signals)
//   dn_checksum - (only with DN_CHECKSUM_EN) mod-256 sum of accepted bytes
// Optional feature macro: DN_CHECKSUM_EN
module dn_mem_arbiter #(
    parameter int AW           = 17,
    parameter int TARGET_INDEX = 0,
    parameter int FIFO_DEPTH   = 4,
    parameter int RST_TAIL     = 16
) (
    input  logic                   clk_24,
    input  logic                   reset_n,
    dn_mem_arbiter_if.slave        bus
`ifdef DN_CHECKSUM_EN
    ,
    output logic [7:0]             dn_checksum
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(RST_TAIL + 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DL_WR    = 2'd1;
    localparam logic [1:0] S_CPU_ACC  = 2'd2;
    localparam logic [1:0] S_CPU_WAIT = 2'd3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } entry_t;

    entry_t          fifo_mem [FIFO_DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count, count_next;
    logic            fifo_empty, fifo_full;
    logic            push, pop;
    logic            idx_match, in_range, strobe;

    logic [1:0]      state;
    logic            cpu_rd;
    logic            dl_q, dl_rise;
    logic            pending, pending_next;
    logic [TW-1:0]   tail, tail_next;
    logic            rst_hold, rst_hold_next;

    assign head       = fifo_mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign idx_match  = (bus.ioctl_index == 8'(TARGET_INDEX));
    // Range check uses the full 25-bit address before truncation to AW.
    assign in_range   = (bus.ioctl_addr[24:AW] == '0);
    assign strobe     = bus.ioctl_wr & bus.ioctl_download & idx_match;
    assign push       = strobe & in_range & ~fifo_full;
    assign pop        = (state == S_IDLE) & ~fifo_empty;
    assign dl_rise    = bus.ioctl_download & ~dl_q;

    // The raw download level is ORed in so a new download re-asserts reset
    // in the same cycle, even in the middle of a tail.
    assign bus.sys_reset = rst_hold | bus.ioctl_download;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        count_next    = count;
        pending_next  = pending;
        tail_next     = tail;
        if (push && !pop)      count_next = count + (PW+1)'(1);
        else if (pop && !push) count_next = count - (PW+1)'(1);

        // pending marks "a download ended, tail not loaded yet"; the tail
        // only starts once the FIFO has fully drained into the RAM.
        if (bus.ioctl_download) begin
            pending_next = 1'b1;
            tail_next    = '0;
        end else if (pending && fifo_empty) begin
            pending_next = 1'b0;
            tail_next    = TW'(RST_TAIL);
        end else if (tail != '0) begin
            tail_next    = tail - TW'(1);
        end
        rst_hold_next = pending_next | (tail_next != '0) | (count_next != '0);
    end

    // NOTE: FIFO storage is deliberately left without reset; only the
    // pointers and count decide what is valid.
    always_ff @(posedge clk_24) begin
        if (push) fifo_mem[wr_ptr] <= '{addr: bus.ioctl_addr[AW-1:0], data: bus.ioctl_dout};
    end

    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            bus.ioctl_wait  <= 1'b0;
            dl_q            <= 1'b0;
            pending         <= 1'b0;
            tail            <= '0;
            rst_hold        <= 1'b1;
            bus.dn_overflow <= 1'b0;
            state           <= S_IDLE;
            cpu_rd          <= 1'b0;
            bus.cpu_ack     <= 1'b0;
            bus.cpu_dout    <= '0;
            bus.mem_addr    <= '0;
            bus.mem_din     <= '0;
            bus.mem_we      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count    <= count_next;
            // Threshold DEPTH-1 leaves one free slot for the strobe that is
            // already in flight while ioctl_wait rises.
            bus.ioctl_wait <= (count_next >= (PW+1)'(FIFO_DEPTH - 1));

            dl_q     <= bus.ioctl_download;
            pending  <= pending_next;
            tail     <= tail_next;
            rst_hold <= rst_hold_next;

            // A drop in the same cycle as a download start still counts.
            if (dl_rise) bus.dn_overflow <= 1'b0;
            if (strobe && !in_range) bus.dn_overflow <= 1'b1;

            bus.mem_we  <= 1'b0;
            bus.cpu_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        bus.mem_addr <= head.addr;
                        bus.mem_din  <= head.data;
                        bus.mem_we   <= 1'b1;
                        state        <= S_DL_WR;
                    // cpu_req is still high in the ack cycle; skip it so the
                    // finished request is not granted twice.
                    end else if (bus.cpu_req && !bus.sys_reset && !bus.cpu_ack) begin
                        bus.mem_addr <= bus.cpu_addr;
                        bus.mem_din  <= bus.cpu_din;
                        bus.mem_we   <= bus.cpu_we;
                        cpu_rd       <= ~bus.cpu_we;
                        state        <= S_CPU_ACC;
                    end
                end
                S_DL_WR:   state <= S_IDLE;
                // RAM samples the address at the end of CPU_ACC; its data is
                // valid during CPU_WAIT.
                S_CPU_ACC: state <= S_CPU_WAIT;
                S_CPU_WAIT: begin
                    if (cpu_rd) bus.cpu_dout <= bus.mem_dout;
                    bus.cpu_ack <= 1'b1;
                    state       <= S_IDLE;
                end
                default:   state <= S_IDLE;
            endcase
        end
    end

`ifdef DN_CHECKSUM_EN
    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n)     dn_checksum <= '0;
        else if (dl_rise) dn_checksum <= push ? bus.ioctl_dout : 8'h00;
        else if (push)    dn_checksum <= dn_checksum + bus.ioctl_dout;
    end
`endif

endmodule

// File: tb/tb_dn_mem_arbiter.sv
// tb_dn_mem_arbiter
//   Directed bench for dn_mem_arbiter with a behavioural RAM (1-cycle
//   registered read) and a write monitor. Inputs are driven 1 time unit after
//   the rising edge; outputs are checked at that same point.
module tb_dn_mem_arbiter;

    localparam int AW = 17;

    logic clk_24 = 1'b0;
    logic reset_n;
    always #5 clk_24 = ~clk_24;

    dn_mem_arbiter_if #(.AW(AW)) bus ();

`ifdef DN_CHECKSUM_EN
    logic [7:0] dn_checksum;
`endif

    dn_mem_arbiter #(
        .AW(AW), .TARGET_INDEX(0), .FIFO_DEPTH(4), .RST_TAIL(16)
    ) dut (
        .clk_24  (clk_24),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef DN_CHECKSUM_EN
        ,
        .dn_checksum (dn_checksum)
`endif
    );

    // Behavioural single-port RAM, registered read.
    logic [7:0] ram [0:(1<<AW)-1];
    always @(posedge clk_24) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= ram[bus.mem_addr];
    end

    // Monitor: cycle counter, write log, ioctl_wait activity.
    int          cyc = 0;
    int          last_we_cyc = 0;
    int          wait_cnt = 0;
    int          wr5_cnt = 0;
    logic [24:0] wlog [$];
    always @(posedge clk_24) cyc <= cyc + 1;
    always @(negedge clk_24) begin
        if (bus.mem_we) begin
            wlog.push_back({bus.mem_addr, bus.mem_din});
            last_we_cyc <= cyc;
            if (bus.mem_addr == 17'd5) wr5_cnt <= wr5_cnt + 1;
        end
        if (bus.ioctl_wait) wait_cnt <= wait_cnt + 1;
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_24);
        #1;
    endtask

    task automatic wait_sys_reset_low(input int limit);
        int k;
        k = 0;
        while (bus.sys_reset !== 1'b0 && k < limit) begin
            step();
            k++;
        end
    endtask

    initial begin
        int n0, w0, sent, guard, cnt;

        reset_n            = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.ioctl_index    = '0;
        bus.cpu_req        = 1'b0;
        bus.cpu_we         = 1'b0;
        bus.cpu_addr       = '0;
        bus.cpu_din        = '0;
        repeat (3) step();

        // Reset state
        check("rst_sys_reset",  32'(bus.sys_reset),   32'd1);
        check("rst_ioctl_wait", 32'(bus.ioctl_wait),  32'd0);
        check("rst_cpu_ack",    32'(bus.cpu_ack),     32'd0);
        check("rst_cpu_dout",   32'(bus.cpu_dout),    32'd0);
        check("rst_mem_we",     32'(bus.mem_we),      32'd0);
        check("rst_mem_addr",   32'(bus.mem_addr),    32'd0);
        check("rst_overflow",   32'(bus.dn_overflow), 32'd0);

        // One cycle after release with no download: everything low
        reset_n = 1'b1;
        step();
        check("rel_sys_reset",  32'(bus.sys_reset),   32'd0);
        check("rel_ioctl_wait", 32'(bus.ioctl_wait),  32'd0);

        // Slow download: 3 bytes, one strobe every 4th cycle
        n0 = wlog.size();
        w0 = wait_cnt;
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = 8'd0;
        for (int i = 0; i < 3; i++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(i);
            bus.ioctl_dout = 8'(8'h11 * (i + 1));
            step();
            bus.ioctl_wr   = 1'b0;
            if (i == 0) check("dl_sys_reset_high", 32'(bus.sys_reset), 32'd1);
            if (i < 2) repeat (3) step();
        end
        bus.ioctl_download = 1'b0;
        wait_sys_reset_low(60);
        // Last write lands with download already low; the tail then holds
        // sys_reset for 16 more cycles, so the first low cycle is 17 later.
        check("tail_length",     32'(cyc - last_we_cyc), 32'd17);
        check("slow_write_count", 32'(wlog.size() - n0), 32'd3);
        check("slow_ram0", 32'(ram[0]), 32'h11);
        check("slow_ram1", 32'(ram[1]), 32'h22);
        check("slow_ram2", 32'(ram[2]), 32'h33);
        check("slow_no_wait", 32'(wait_cnt - w0), 32'd0);

        // Back-to-back burst of 6; the HPS holds whenever ioctl_wait is high
        n0 = wlog.size();
        w0 = wait_cnt;
        sent = 0;
        guard = 0;
        bus.ioctl_download = 1'b1;
        while (sent < 6 && guard < 50) begin
            if (!bus.ioctl_wait) begin
                bus.ioctl_wr   = 1'b1;
                bus.ioctl_addr = 25'(32'h40 + sent);
                bus.ioctl_dout = 8'(8'hA0 + sent);
                sent++;
            end else begin
                bus.ioctl_wr = 1'b0;
            end
            step();
            guard++;
        end
        bus.ioctl_wr = 1'b0;
        // Pushes in cycles 1-5, wait high in cycle 6, last push in cycle 7.
        check("burst_cycles", 32'(guard), 32'd7);
        repeat (8) step();
        check("burst_wait_seen", 32'(wait_cnt != w0), 32'd1);
        check("burst_write_count", 32'(wlog.size() - n0), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (n0 + i < wlog.size())
                check($sformatf("burst_word%0d", i), 32'(wlog[n0 + i]),
                      32'({17'(32'h40 + i), 8'(8'hA0 + i)}));
        end
        check("burst_wait_released", 32'(bus.ioctl_wait), 32'd0);

        // Drops: foreign index, then out-of-range address
        n0 = wlog.size();
        bus.ioctl_wr    = 1'b1;
        bus.ioctl_index = 8'd1;
        bus.ioctl_addr  = 25'd5;
        bus.ioctl_dout  = 8'hAA;
        step();
        bus.ioctl_wr = 1'b0;
        step();
        check("ovf_after_index_drop", 32'(bus.dn_overflow), 32'd0);
        bus.ioctl_wr    = 1'b1;
        bus.ioctl_index = 8'd0;
        bus.ioctl_addr  = 25'h20000;
        bus.ioctl_dout  = 8'hBB;
        step();
        bus.ioctl_wr = 1'b0;
        check("ovf_after_range_drop", 32'(bus.dn_overflow), 32'd1);
        repeat (4) step();
        check("drop_no_writes", 32'(wlog.size() - n0), 32'd0);
        check("drop_ram5_untouched", 32'(wr5_cnt), 32'd0);
        bus.ioctl_download = 1'b0;
        step();
        check("ovf_sticky", 32'(bus.dn_overflow), 32'd1);
        wait_sys_reset_low(60);
        check("idle_before_restart", 32'(bus.sys_reset), 32'd0);
        bus.ioctl_download = 1'b1;
        #1;
        check("restart_sys_reset_immediate", 32'(bus.sys_reset), 32'd1);
        step();
        check("ovf_cleared_on_start", 32'(bus.dn_overflow), 32'd0);

`ifdef DN_CHECKSUM_EN
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'h10;
        bus.ioctl_dout = 8'hFF;
        step();
        bus.ioctl_addr = 25'h11;
        bus.ioctl_dout = 8'h02;
        step();
        bus.ioctl_wr = 1'b0;
        check("checksum_sum", 32'(dn_checksum), 32'h01);
        bus.ioctl_download = 1'b0;
        repeat (3) step();
        check("checksum_frozen", 32'(dn_checksum), 32'h01);
        bus.ioctl_download = 1'b1;
        step();
        check("checksum_cleared", 32'(dn_checksum), 32'h00);
`endif

        bus.ioctl_download = 1'b0;
        wait_sys_reset_low(80);
        check("cpu_phase_sys_reset", 32'(bus.sys_reset), 32'd0);

        // CPU write 0x5A to 0x100: grant at the first edge, ack 2 cycles later
        n0 = wlog.size();
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b1;
        bus.cpu_addr = 17'h100;
        bus.cpu_din  = 8'h5A;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!bus.cpu_ack && cnt < 20);
        check("cpu_wr_ack_latency", 32'(cnt), 32'd3);
        bus.cpu_req = 1'b0;
        step();
        check("cpu_wr_ack_pulse", 32'(bus.cpu_ack), 32'd0);
        check("cpu_wr_single_write", 32'(wlog.size() - n0), 32'd1);
        check("cpu_wr_ram", 32'(ram[17'h100]), 32'h5A);

        // CPU read back
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b0;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!bus.cpu_ack && cnt < 20);
        check("cpu_rd_ack_latency", 32'(cnt), 32'd3);
        check("cpu_rd_data", 32'(bus.cpu_dout), 32'h5A);
        bus.cpu_req = 1'b0;
        step();
        check("cpu_rd_ack_pulse", 32'(bus.cpu_ack), 32'd0);
        check("cpu_rd_no_write", 32'(wlog.size() - n0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
